weight_bias_bank: RTL and testbench
===================================

Name: weight_bias_bank

Overview:
- Downstream consumer of the weight/bias FIFO stage.
- Issues one-cycle change_weight_bias commands to that stage, captures the returned beats (one-hot valid[8:0]) into a shadow bank, then swaps shadow to active on PE-array request.
- PE array reads active weights through a registered tap port, so the next layer's weights load while the current layer computes.

Parameters:
- WEIGHT_WIDTH, 16, bits per weight lane.
- PE_CORE_NUM, 16, lanes per beat; beat width DW = PE_CORE_NUM*WEIGHT_WIDTH (256).
- SLOT_NUM, 8, weight slots (one-hot bits [7:0]).
- KERNEL_TAPS, 9, beats per slot (3x3 kernel).

Ports:
- system_clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_req  in  1  pulse: start loading the shadow bank.
- load_mode  in  2  sampled with load_req; 01 weight, 10 bias, 11 weight+bias; 00 ignored.
- load_busy  out  1  high from accepted load_req until shadow full.
- shadow_ready  out  1  shadow bank complete, awaiting swap.
- change_weight_bias  out  2  command to the FIFO stage; nonzero for exactly one cycle per load.
- weight_and_bias_ready  in  1  FIFO stage idle and able to take a command.
- weight_bias_data  in  DW  beat data from the FIFO stage.
- weight_bias_valid  in  9  one-hot beat qualifier; bits [7:0] weight slot, bit 8 bias.
- swap_req  in  1  PE array at tile boundary; swap if shadow_ready.
- swap_done  out  1  one-cycle pulse, cycle after swap.
- rd_slot  in  3  active-bank slot select.
- rd_tap  in  4  active-bank tap select (0..8).
- rd_data  out  DW  registered weight, latency 1.
- bias_data  out  DW  active bias register.
- task_finish  in  1  abort/clear, same effect as the clear path below.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0; FSM IDLE; both banks' valid flags cleared. Bank contents are not reset.
- FSM states: IDLE, CMD, FILL, FULL.
- IDLE: load_req with load_mode != 0 -> latch mode, go to CMD. load_req with mode 00 -> no action.
- CMD: while weight_and_bias_ready=1, drive change_weight_bias=mode for one cycle, then go to FILL. Never hold the command for 2 cycles, because the FIFO stage re-samples it every idle cycle.
- FILL: each cycle with valid != 0, write the beat.
  - Bit k<8 set: shadow[k][tap_cnt] <= data; tap_cnt increments, wrapping 8->0.
  - Bit 8 set: shadow_bias <= data.
- Expected beats: mode 01 = 72, mode 10 = 1, mode 11 = 73 (bias last). When the beat count reaches expected, go to FULL: shadow_ready=1, load_busy=0.
- FULL, on swap_req: copy shadow to active (or bank-pointer flip), pulse swap_done next cycle, return to IDLE.
  - Mode 10 swaps only the bias. Mode 01 keeps the old active bias.
- swap_req when not FULL: ignored. No pulse, no error.
- load_req when not IDLE: ignored, and protocol_err set.
- Valid with more than one bit set, valid outside FILL, or slot order non-ascending: protocol_err set, beat dropped.
- rd_*: rd_data <= active[rd_slot][rd_tap] on the next edge. rd_tap > 8 returns 0. The read is unaffected during the swap cycle (returns the pre-swap value); new data appears the cycle after swap.
- task_finish or rst mid-FILL: FSM to IDLE, counters 0, shadow_ready 0. Active bank and bias are retained under task_finish, while rst clears valid flags. protocol_err is cleared only by rst.
- Simultaneous swap_req and load_req in FULL: the swap takes priority. load_req is not queued and raises protocol_err.

Decomposition:
- Shared package/defines:
  - WEIGHT_WIDTH, PE_CORE_NUM, KERNEL_TAPS, SLOT_NUM.
  - Mode encodings MODE_NONE/WEIGHT/BIAS/BOTH (match the FIFO stage's 2-bit code).
  - FSM state constants.
  - Expected-beat constants 72/1/73.
- Sub-module: weight_bank_ram. 2 banks × 72 × DW, one write port and one registered read port, with a bank-select bit; the swap then becomes a pointer flip.

Test Plan:
- Mode 01 load, beats slot0..7 × 9 with data = {slot,tap} pattern -> one command cycle; shadow_ready after 72nd beat; swap; rd_slot=3, rd_tap=5 returns pattern 0x35 one cycle later.
- Mode 11 load, 73 beats -> bias_data equals beat 73 after swap; weights as above; swap_done is a single-cycle pulse.
- weight_and_bias_ready held 0 for 10 cycles in CMD -> change_weight_bias stays 00 until ready, then nonzero for exactly 1 cycle.
- task_finish after 30 beats -> IDLE, shadow_ready=0, active reads unchanged; a fresh load completes normally.
- valid=9'b000000011 during FILL -> protocol_err=1, beat count unchanged; load_req while FULL -> ignored, protocol_err=1.
- Reads during the swap cycle -> old data that cycle, new data the next; rd_tap=12 -> 0.

Source files
------------

// File: rtl/weight_bias_bank_pkg.sv
// weight_bias_bank_pkg: shared sizes, mode/state encodings and beat counts for the weight/bias bank
package weight_bias_bank_pkg;

    localparam int WEIGHT_WIDTH = 16;
    localparam int PE_CORE_NUM  = 16;
    localparam int SLOT_NUM     = 8;
    localparam int KERNEL_TAPS  = 9;
    localparam int DW           = PE_CORE_NUM * WEIGHT_WIDTH;
    localparam int BANK_DEPTH   = SLOT_NUM * KERNEL_TAPS;
    localparam int AW           = 7;

    localparam int BEATS_WEIGHT = 72;
    localparam int BEATS_BIAS   = 1;
    localparam int BEATS_BOTH   = 73;

    typedef enum logic [1:0] {
        MODE_NONE   = 2'b00,
        MODE_WEIGHT = 2'b01,
        MODE_BIAS   = 2'b10,
        MODE_BOTH   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {IDLE, CMD, FILL, FULL} state_e;

    function automatic logic [6:0] expected_beats(input mode_e m);
        return m == MODE_WEIGHT ? 7'(BEATS_WEIGHT) :
               m == MODE_BIAS   ? 7'(BEATS_BIAS)   :
               m == MODE_BOTH   ? 7'(BEATS_BOTH)   : 7'd0;
    endfunction

endpackage

// File: rtl/weight_bank_ram.sv
// weight_bank_ram: two 72-entry weight banks, one write port and one registered read port
module weight_bank_ram
    import weight_bias_bank_pkg::*;
(
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          wbank_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rbank_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2][BANK_DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[wbank_i][waddr_i] <= wdata_i;
        rdata_q <= mem_q[rbank_i][raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_bias_bank.sv
// weight_bias_bank: loads a shadow weight/bias bank from the FIFO stage and swaps it active on request
module weight_bias_bank
    import weight_bias_bank_pkg::*;
(
    input  logic          system_clk,
    input  logic          rst,
    input  logic          load_req,
    input  logic [1:0]    load_mode,
    output logic          load_busy,
    output logic          shadow_ready,
    output logic [1:0]    change_weight_bias,
    input  logic          weight_and_bias_ready,
    input  logic [DW-1:0] weight_bias_data,
    input  logic [8:0]    weight_bias_valid,
    input  logic          swap_req,
    output logic          swap_done,
    input  logic [2:0]    rd_slot,
    input  logic [3:0]    rd_tap,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] bias_data,
    input  logic          task_finish,
    output logic          protocol_err
);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [3:0]    tap_q, tap_d;
    logic [2:0]    slot_q, slot_d;
    logic          err_q, err_d;
    logic          swap_done_q, swap_done_d;
    logic          act_q, act_d;
    logic          rd_ok_q, rd_ok_d;
    logic [1:0]    bank_vld_q, bank_vld_d;
    logic [DW-1:0] bias_q, bias_d, sh_bias_q;
    logic          onehot, w_beat, b_beat;
    logic [AW-1:0] raddr;
    logic [DW-1:0] ram_rdata;

    // Beats are accepted only in FILL, one-hot, in slot order, and with bias strictly after weights.
    assign onehot = weight_bias_valid != 9'd0 && (weight_bias_valid & (weight_bias_valid - 9'd1)) == 9'd0;
    assign w_beat = state_q == FILL && onehot && mode_q[0] && cnt_q < 7'(BEATS_WEIGHT)
                    && weight_bias_valid[7:0] == (8'd1 << slot_q);
    assign b_beat = state_q == FILL && weight_bias_valid == 9'h100 && mode_q[1]
                    && cnt_q == (mode_q[0] ? 7'(BEATS_WEIGHT) : 7'd0);
    assign raddr  = rd_tap < 4'(KERNEL_TAPS) ? {4'd0, rd_slot} * 7'd9 + {3'd0, rd_tap} : 7'd0;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        tap_d       = tap_q;
        slot_d      = slot_q;
        err_d       = err_q;
        swap_done_d = 1'b0;
        act_d       = act_q;
        bank_vld_d  = bank_vld_q;
        bias_d      = bias_q;
        rd_ok_d     = rd_tap < 4'(KERNEL_TAPS) && bank_vld_q[act_q];
        if ((load_req && state_q != IDLE) || (weight_bias_valid != 9'd0 && !w_beat && !b_beat)) err_d = 1'b1;
        if (w_beat) begin
            cnt_d  = cnt_q + 7'd1;
            tap_d  = tap_q == 4'd8 ? 4'd0 : tap_q + 4'd1;
            slot_d = tap_q == 4'd8 ? slot_q + 3'd1 : slot_q;
        end
        if (b_beat) cnt_d = cnt_q + 7'd1;
        case (state_q)
            IDLE: if (load_req && load_mode != MODE_NONE) begin
                mode_d  = mode_e'(load_mode);
                state_d = CMD;
                cnt_d   = 7'd0;
                tap_d   = 4'd0;
                slot_d  = 3'd0;
            end
            CMD:  if (weight_and_bias_ready) state_d = FILL;
            FILL: if (cnt_d == expected_beats(mode_q)) state_d = FULL;
            FULL: if (swap_req) begin
                state_d     = IDLE;
                swap_done_d = 1'b1;
                if (mode_q[0]) begin
                    act_d             = ~act_q;
                    bank_vld_d[~act_q] = 1'b1;
                end
                if (mode_q[1]) bias_d = sh_bias_q;
            end
        endcase
        if (task_finish) begin
            state_d = IDLE;
            cnt_d   = 7'd0;
            tap_d   = 4'd0;
            slot_d  = 3'd0;
        end
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_NONE;
            cnt_q       <= 7'd0;
            tap_q       <= 4'd0;
            slot_q      <= 3'd0;
            err_q       <= 1'b0;
            swap_done_q <= 1'b0;
            act_q       <= 1'b0;
            rd_ok_q     <= 1'b0;
            bank_vld_q  <= 2'b00;
            bias_q      <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            tap_q       <= tap_d;
            slot_q      <= slot_d;
            err_q       <= err_d;
            swap_done_q <= swap_done_d;
            act_q       <= act_d;
            rd_ok_q     <= rd_ok_d;
            bank_vld_q  <= bank_vld_d;
            bias_q      <= bias_d;
        end
    end

    always_ff @(posedge system_clk) begin
        if (b_beat) sh_bias_q <= weight_bias_data;
    end

    weight_bank_ram u_ram (
        .clk_i   (system_clk),
        .we_i    (w_beat),
        .wbank_i (~act_q),
        .waddr_i (cnt_q),
        .wdata_i (weight_bias_data),
        .rbank_i (act_q),
        .raddr_i (raddr),
        .rdata_o (ram_rdata)
    );

    assign load_busy          = state_q == CMD || state_q == FILL;
    assign shadow_ready       = state_q == FULL;
    assign change_weight_bias = state_q == CMD && weight_and_bias_ready ? mode_q : MODE_NONE;
    assign swap_done          = swap_done_q;
    assign rd_data            = rd_ok_q ? ram_rdata : '0;
    assign bias_data          = bias_q;
    assign protocol_err       = err_q;

endmodule

// File: tb/tb_weight_bias_bank.sv
// tb_weight_bias_bank: directed, table-driven checks of load, swap, read and error behaviour
module tb_weight_bias_bank;
    import weight_bias_bank_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_req = 1'b0;
    logic [1:0]    load_mode = 2'b00;
    logic          load_busy, shadow_ready, swap_done, protocol_err;
    logic [1:0]    change_weight_bias;
    logic          ready = 1'b1;
    logic [DW-1:0] wb_data = '0;
    logic [8:0]    wb_valid = 9'd0;
    logic          swap_req = 1'b0;
    logic [2:0]    rd_slot = 3'd0;
    logic [3:0]    rd_tap = 4'd0;
    logic [DW-1:0] rd_data, bias_data;
    logic          task_finish = 1'b0;

    int tests = 0;
    int fails = 0;
    int cmd_cycles = 0;

    typedef struct {
        logic [2:0]    slot;
        logic [3:0]    tap;
        logic [DW-1:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [7];

    always #5 clk = ~clk;

    always @(negedge clk) if (change_weight_bias != 2'b00) cmd_cycles <= cmd_cycles + 1;

    weight_bias_bank dut (
        .system_clk            (clk),
        .rst                   (rst),
        .load_req              (load_req),
        .load_mode             (load_mode),
        .load_busy             (load_busy),
        .shadow_ready          (shadow_ready),
        .change_weight_bias    (change_weight_bias),
        .weight_and_bias_ready (ready),
        .weight_bias_data      (wb_data),
        .weight_bias_valid     (wb_valid),
        .swap_req              (swap_req),
        .swap_done             (swap_done),
        .rd_slot               (rd_slot),
        .rd_tap                (rd_tap),
        .rd_data               (rd_data),
        .bias_data             (bias_data),
        .task_finish           (task_finish),
        .protocol_err          (protocol_err)
    );

    function automatic logic [DW-1:0] beat(input int layer, input int s, input int t);
        return {8'(layer), 240'd0, 4'(s), 4'(t)};
    endfunction

    function automatic logic [DW-1:0] bias(input int layer);
        return {8'(layer), 240'd0, 8'hB1};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic start_load(input logic [1:0] m);
        load_req  = 1'b1;
        load_mode = m;
        tick;
        load_req  = 1'b0;
        load_mode = 2'b00;
    endtask

    task automatic send_beats(input int layer, input int first, input int last, input int bad_at);
        for (int i = first; i <= last; i++) begin
            if (i == bad_at) begin
                wb_valid = 9'b000000011;
                wb_data  = '1;
                tick;
            end
            wb_valid = 9'd1 << (i / 9);
            wb_data  = beat(layer, i / 9, i % 9);
            tick;
        end
        wb_valid = 9'd0;
    endtask

    task automatic send_bias(input int layer);
        wb_valid = 9'h100;
        wb_data  = bias(layer);
        tick;
        wb_valid = 9'd0;
    endtask

    task automatic do_swap;
        swap_req = 1'b1;
        tick;
        swap_req = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [2:0] s, input logic [3:0] t, input logic [DW-1:0] exp);
        rd_slot = s;
        rd_tap  = t;
        tick;
        check(name, rd_data, exp);
    endtask

    initial begin
        vecs[0] = '{3'd3, 4'd5,  beat(1, 3, 5)};
        vecs[1] = '{3'd0, 4'd0,  beat(1, 0, 0)};
        vecs[2] = '{3'd7, 4'd8,  beat(1, 7, 8)};
        vecs[3] = '{3'd1, 4'd4,  beat(1, 1, 4)};
        vecs[4] = '{3'd3, 4'd12, '0};
        vecs[5] = '{3'd7, 4'd9,  '0};
        vecs[6] = '{3'd0, 4'd15, '0};

        repeat (3) tick;
        rst = 1'b0;
        check("rst_busy", load_busy, 0);
        check("rst_ready", shadow_ready, 0);
        check("rst_cmd", change_weight_bias, 0);
        check("rst_swap_done", swap_done, 0);
        check("rst_err", protocol_err, 0);
        check("rst_bias", bias_data, '0);
        read_check("rst_rd", 3'd3, 4'd5, '0);

        // mode 00 is ignored
        start_load(2'b00);
        check("mode00_busy", load_busy, 0);

        // layer 1: weights only
        start_load(2'b01);
        check("l1_busy", load_busy, 1);
        check("l1_cmd", change_weight_bias, 2'b01);
        tick;
        check("l1_cmd_once", change_weight_bias, 2'b00);
        send_beats(1, 0, 70, -1);
        check("l1_not_full", shadow_ready, 0);
        send_beats(1, 71, 71, -1);
        check("l1_full", shadow_ready, 1);
        check("l1_busy_off", load_busy, 0);
        do_swap;
        check("l1_swap_done", swap_done, 1);
        tick;
        check("l1_swap_done_off", swap_done, 0);
        foreach (vecs[i]) read_check($sformatf("l1_rd%0d", i), vecs[i].slot, vecs[i].tap, vecs[i].exp);
        check("l1_bias_kept", bias_data, '0);

        // layer 2: weights + bias, command held off by ready
        ready = 1'b0;
        start_load(2'b11);
        for (int i = 0; i < 10; i++) begin
            check("l2_cmd_wait", change_weight_bias, 2'b00);
            tick;
        end
        check("l2_busy", load_busy, 1);
        ready = 1'b1;
        #1;
        check("l2_cmd", change_weight_bias, 2'b11);
        tick;
        check("l2_cmd_once", change_weight_bias, 2'b00);
        send_beats(2, 0, 71, -1);
        check("l2_wait_bias", shadow_ready, 0);
        send_bias(2);
        check("l2_full", shadow_ready, 1);
        rd_slot  = 3'd3;
        rd_tap   = 4'd5;
        swap_req = 1'b1;
        tick;
        swap_req = 1'b0;
        check("l2_rd_swap_cycle", rd_data, beat(1, 3, 5));
        check("l2_swap_done", swap_done, 1);
        check("l2_bias", bias_data, bias(2));
        tick;
        check("l2_rd_after", rd_data, beat(2, 3, 5));
        check("l2_swap_done_off", swap_done, 0);
        read_check("l2_rd_7_8", 3'd7, 4'd8, beat(2, 7, 8));

        // layer 3 aborted after 30 beats, layer 4 completes afterwards
        start_load(2'b01);
        tick;
        send_beats(3, 0, 29, -1);
        task_finish = 1'b1;
        tick;
        task_finish = 1'b0;
        check("tf_ready", shadow_ready, 0);
        check("tf_busy", load_busy, 0);
        read_check("tf_rd", 3'd3, 4'd5, beat(2, 3, 5));
        read_check("tf_rd0", 3'd0, 4'd0, beat(2, 0, 0));
        start_load(2'b01);
        tick;
        send_beats(4, 0, 71, -1);
        check("l4_full", shadow_ready, 1);
        do_swap;
        read_check("l4_rd", 3'd3, 4'd5, beat(4, 3, 5));
        read_check("l4_rd0", 3'd0, 4'd1, beat(4, 0, 1));
        check("l4_bias_kept", bias_data, bias(2));
        check("l4_err", protocol_err, 0);

        // layer 5: bias only; load_req in FULL, then swap+load_req together
        start_load(2'b10);
        tick;
        send_bias(5);
        check("l5_full", shadow_ready, 1);
        check("l5_bias_pre", bias_data, bias(2));
        start_load(2'b01);
        check("full_load_err", protocol_err, 1);
        check("full_load_ignored", shadow_ready, 1);
        swap_req  = 1'b1;
        load_req  = 1'b1;
        load_mode = 2'b01;
        tick;
        swap_req  = 1'b0;
        load_req  = 1'b0;
        load_mode = 2'b00;
        check("l5_swap_done", swap_done, 1);
        check("l5_not_queued", load_busy, 0);
        check("l5_bias", bias_data, bias(5));
        read_check("l5_rd_weights", 3'd3, 4'd5, beat(4, 3, 5));
        check("l5_busy_still", load_busy, 0);

        // reset clears error and bank valid flags
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst2_err", protocol_err, 0);
        check("rst2_bias", bias_data, '0);
        read_check("rst2_rd", 3'd3, 4'd5, '0);

        // layer 6: multi-hot valid mid-fill is dropped
        start_load(2'b01);
        tick;
        send_beats(6, 0, 70, 4);
        check("mh_err", protocol_err, 1);
        check("mh_not_full", shadow_ready, 0);
        send_beats(6, 71, 71, -1);
        check("mh_full", shadow_ready, 1);
        do_swap;
        read_check("mh_rd_0_4", 3'd0, 4'd4, beat(6, 0, 4));
        read_check("mh_rd_7_8", 3'd7, 4'd8, beat(6, 7, 8));

        // swap_req outside FULL is ignored
        do_swap;
        check("idle_swap_ignored", swap_done, 0);

        tick;
        check("cmd_cycles", 32'(cmd_cycles), 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
